loop_player: RTL and testbench

// Read side of the recorder buffer. Plays a recorded clip out of the audio sample BRAM at the audio sample rate.
// One BRAM read is issued per audio_valid_in strobe; each returned sample is attenuated and presented to the mixer/PWM path.

---
 rtl/loop_player_if.sv | 19 +
 rtl/loop_player.sv | 159 +++++++++++++++
 tb/tb_loop_player.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/loop_player_if.sv
// rtl/loop_player_if.sv - BRAM read-port bundle between loop_player and recorder RAM port B
//
// Signals:
//   rd_addr_out  BRAM read address (player -> RAM)
//   rd_en_out    one-cycle read enable per fetch (player -> RAM)
//   rd_data_in   signed read data, valid a fixed latency after rd_en_out (RAM -> player)
// Modports: master = player side, slave = RAM side.

interface loop_player_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rd_addr_out;
    logic              rd_en_out;
    logic [DATA_W-1:0] rd_data_in;

    modport master (output rd_addr_out, output rd_en_out, input rd_data_in);
    modport slave  (input rd_addr_out, input rd_en_out, output rd_data_in);
endinterface

// File: rtl/loop_player.sv
// rtl/loop_player.sv - plays a recorded clip from BRAM at the audio sample rate
//
// Ports:
//   clk_in, rst_n_in    clock, asynchronous active-low reset
//   start_in, stop_in   one-cycle control pulses (start wins when both)
//   loop_in             1 = wrap at clip end, 0 = finish (sampled live at clip end)
//   length_in, shift_in clip length and attenuation, captured on an accepted start
//   audio_valid_in      sample-rate tick; one BRAM fetch per tick while armed
//   rd                  BRAM read port (loop_player_if.master)
//   sample_out          attenuated signed sample, held between valids
//   sample_valid_out    one-cycle pulse when sample_out updates
//   playing_out         high while armed or fetching
//   done_out            one-cycle pulse with the last sample of a one-shot clip
//   overrun_out         saturating count of ticks dropped during a fetch

module loop_player #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int RAM_LATENCY = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     start_in,
    input  logic                     stop_in,
    input  logic                     loop_in,
    input  logic [ADDR_W-1:0]        length_in,
    input  logic [2:0]               shift_in,
    input  logic                     audio_valid_in,
    loop_player_if.master            rd,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     sample_valid_out,
    output logic                     playing_out,
    output logic                     done_out,
    output logic [7:0]               overrun_out
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;

    localparam logic [2:0]        LAT      = 3'(RAM_LATENCY);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]               state_q, state_d;
    logic [ADDR_W-1:0]        ptr_q, ptr_d;
    logic [ADDR_W-1:0]        len_q, len_d;
    logic [2:0]               shift_q, shift_d;
    logic [2:0]               lat_q, lat_d;
    logic signed [DATA_W-1:0] sample_q, sample_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;
    logic [7:0]               ovr_q, ovr_d;

    logic                     start_ok;
    logic                     fetch_go;
    logic signed [DATA_W-1:0] data_s;

    // A zero-length start is ignored entirely, so it can neither restart nor clear.
    assign start_ok = start_in && (length_in != '0);
    // Fetch is suppressed when a start or stop lands on the same tick.
    assign fetch_go = (state_q == S_ARMED) && audio_valid_in && !start_ok && !stop_in;
    assign data_s   = rd.rd_data_in;

    assign rd.rd_en_out   = fetch_go;
    assign rd.rd_addr_out = ptr_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        shift_d  = shift_q;
        lat_d    = lat_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        ovr_d    = ovr_q;

        // Ticks arriving while a read is in flight are dropped, only counted.
        if (state_q == S_FETCH && audio_valid_in && ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
        end

        if (start_ok) begin
            state_d = S_ARMED;
            ptr_d   = '0;
            len_d   = length_in;
            shift_d = shift_in;
            lat_d   = '0;
            ovr_d   = '0;
        end else if (stop_in) begin
            state_d  = S_IDLE;
            ptr_d    = '0;
            lat_d    = '0;
            sample_d = '0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (fetch_go) begin
                        state_d = S_FETCH;
                        lat_d   = 3'd1;
                    end
                end
                S_FETCH: begin
                    // lat_q counts cycles since rd_en_out; data is on the bus at LAT.
                    if (lat_q == LAT) begin
                        sample_d = data_s >>> shift_q;
                        valid_d  = 1'b1;
                        lat_d    = '0;
                        if (ptr_q == len_q - ADDR_ONE) begin
                            ptr_d = '0;
                            if (loop_in) begin
                                state_d = S_ARMED;
                            end else begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            ptr_d   = ptr_q + ADDR_ONE;
                            state_d = S_ARMED;
                        end
                    end else begin
                        lat_d = lat_q + 3'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            len_q    <= '0;
            shift_q  <= '0;
            lat_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            shift_q  <= shift_d;
            lat_q    <= lat_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    assign sample_out       = sample_q;
    assign sample_valid_out = valid_q;
    assign done_out         = done_q;
    assign overrun_out      = ovr_q;
    assign playing_out      = (state_q == S_ARMED) || (state_q == S_FETCH);

endmodule

// File: tb/tb_loop_player.sv
// tb/tb_loop_player.sv - self-checking bench for loop_player with a latency-2 BRAM model

module tb_loop_player;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_r = 1'b0;
    logic              audio_valid = 1'b0;
    logic [15:0]       length = '0;
    logic [2:0]        shift = '0;
    logic signed [7:0] sample_out;
    logic              sample_valid_out;
    logic              playing_out;
    logic              done_out;
    logic [7:0]        overrun_out;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic signed [7:0] s;
        logic              d;
        logic [15:0]       a;
    } exp_t;
    exp_t exp_q[$];

    logic signed [7:0] mem [0:15];
    logic [15:0]       pa0, pa1;
    logic              pv0 = 1'b0;
    logic              pv1 = 1'b0;

    loop_player_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    loop_player #(.ADDR_W(16), .DATA_W(8), .RAM_LATENCY(2)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .stop_in(stop),
        .loop_in(loop_r), .length_in(length), .shift_in(shift),
        .audio_valid_in(audio_valid), .rd(bus),
        .sample_out(sample_out), .sample_valid_out(sample_valid_out),
        .playing_out(playing_out), .done_out(done_out), .overrun_out(overrun_out)
    );

    always #5 clk = ~clk;

    // BRAM model: data for an address appears two cycles after its read enable.
    always @(posedge clk) begin
        pv0 <= bus.rd_en_out;
        pa0 <= bus.rd_addr_out;
        pv1 <= pv0;
        pa1 <= pa0;
    end
    always_comb bus.rd_data_in = pv1 ? mem[pa1[3:0]] : 8'h55;

    task automatic pulse_start(input logic [15:0] len, input logic [2:0] sh, input logic lp);
        @(posedge clk); #1 start = 1'b1; length = len; shift = sh; loop_r = lp;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Drives one tick and reports what the DUT did in the following 8 cycles.
    task automatic do_tick(output logic got, output logic signed [7:0] s, output int lat,
                           output logic dn, output logic en, output logic [15:0] a);
        got = 1'b0; s = '0; lat = 0; dn = 1'b0;
        @(posedge clk); #1 audio_valid = 1'b1;
        @(negedge clk); en = bus.rd_en_out; a = bus.rd_addr_out;
        @(posedge clk); #1 audio_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!got && sample_valid_out) begin
                got = 1'b1; s = sample_out; lat = k; dn = done_out;
            end
        end
    endtask

    task automatic load_clip();
        mem[0] = 8'sd10; mem[1] = -8'sd20; mem[2] = 8'sd30; mem[3] = -8'sd40;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if ({sample_out, sample_valid_out, playing_out, done_out, overrun_out} !== 19'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {sample_out, sample_valid_out, playing_out, done_out, overrun_out});
        end
        n_cmp++; if ({bus.rd_en_out, bus.rd_addr_out} !== 17'd0) begin
            n_fail++; $display("FAIL reset_rd: got %h want 0", {bus.rd_en_out, bus.rd_addr_out});
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_oneshot();
        logic got, dn, en; logic signed [7:0] s; int lat; logic [15:0] a; exp_t e;
        int clip [4] = '{10, -20, 30, -40};
        load_clip();
        pulse_start(16'd4, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            e.s = 8'(clip[i]); e.d = (i == 3); e.a = 16'(i);
            exp_q.push_back(e);
            do_tick(got, s, lat, dn, en, a);
            e = exp_q.pop_front();
            n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL oneshot_valid[%0d]: got %b want 1", i, got); end
            n_cmp++; if (s !== e.s) begin n_fail++; $display("FAIL oneshot_sample[%0d]: got %0d want %0d", i, s, e.s); end
            n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL oneshot_latency[%0d]: got %0d want 3", i, lat); end
            n_cmp++; if (dn !== e.d) begin n_fail++; $display("FAIL oneshot_done[%0d]: got %b want %b", i, dn, e.d); end
            n_cmp++; if ({en, a} !== {1'b1, e.a}) begin n_fail++; $display("FAIL oneshot_rd[%0d]: got en=%b addr=%0d want en=1 addr=%0d", i, en, a, e.a); end
            repeat (11) @(posedge clk);
        end
        @(negedge clk);
        n_cmp++; if (playing_out !== 1'b0) begin n_fail++; $display("FAIL oneshot_playing_after: got %b want 0", playing_out); end
    endtask

    task automatic test_loop();
        logic got, dn, en; logic signed [7:0] s; int lat; logic [15:0] a; exp_t e;
        int clip [4] = '{10, -20, 30, -40};
        load_clip();
        pulse_start(16'd4, 3'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            e.s = 8'(clip[i % 4]); e.d = 1'b0; e.a = 16'(i % 4);
            exp_q.push_back(e);
            do_tick(got, s, lat, dn, en, a);
            e = exp_q.pop_front();
            n_cmp++; if ({got, s} !== {1'b1, e.s}) begin n_fail++; $display("FAIL loop_sample[%0d]: got v=%b %0d want v=1 %0d", i, got, s, e.s); end
            n_cmp++; if (dn !== e.d) begin n_fail++; $display("FAIL loop_done[%0d]: got %b want 0", i, dn); end
            n_cmp++; if (a !== e.a) begin n_fail++; $display("FAIL loop_addr[%0d]: got %0d want %0d", i, a, e.a); end
        end
        @(negedge clk);
        n_cmp++; if (playing_out !== 1'b1) begin n_fail++; $display("FAIL loop_playing: got %b want 1", playing_out); end
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic test_shift();
        logic got, dn, en; logic signed [7:0] s; int lat; logic [15:0] a; exp_t e;
        int want [2] = '{-32, 31};
        mem[0] = -8'sd128; mem[1] = 8'sd127;
        pulse_start(16'd2, 3'd2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            e.s = 8'(want[i]); e.d = (i == 1); e.a = 16'(i);
            exp_q.push_back(e);
            do_tick(got, s, lat, dn, en, a);
            e = exp_q.pop_front();
            n_cmp++; if ({got, s, dn} !== {1'b1, e.s, e.d}) begin n_fail++; $display("FAIL shift_sample[%0d]: got v=%b %0d done=%b want v=1 %0d done=%b", i, got, s, dn, e.s, e.d); end
        end
    endtask

    task automatic test_overrun();
        int valids = 0;
        load_clip();
        pulse_start(16'd4, 3'd0, 1'b1);
        for (int p = 0; p < 300; p++) begin
            @(posedge clk); #1 audio_valid = 1'b1;
            @(posedge clk); #1 audio_valid = 1'b1;
            @(posedge clk); #1 audio_valid = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (sample_valid_out) valids++;
            end
            if (p == 0) begin
                n_cmp++; if (overrun_out !== 8'd1) begin n_fail++; $display("FAIL overrun_first: got %0d want 1", overrun_out); end
                n_cmp++; if (valids !== 1) begin n_fail++; $display("FAIL overrun_one_sample: got %0d want 1", valids); end
            end
        end
        n_cmp++; if (overrun_out !== 8'd255) begin n_fail++; $display("FAIL overrun_saturate: got %0d want 255", overrun_out); end
        n_cmp++; if (valids !== 300) begin n_fail++; $display("FAIL overrun_samples: got %0d want 300", valids); end
        pulse_start(16'd4, 3'd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (overrun_out !== 8'd0) begin n_fail++; $display("FAIL overrun_clear: got %0d want 0", overrun_out); end
    endtask

    task automatic test_stop();
        logic got, dn, en; logic signed [7:0] s; int lat; logic [15:0] a;
        int valids = 0;
        int ens = 0;
        load_clip();
        pulse_start(16'd4, 3'd0, 1'b0);
        do_tick(got, s, lat, dn, en, a);
        n_cmp++; if ({got, s} !== {1'b1, 8'sd10}) begin n_fail++; $display("FAIL stop_pre_sample: got v=%b %0d want v=1 10", got, s); end
        @(posedge clk); #1 audio_valid = 1'b1;
        @(posedge clk); #1 audio_valid = 1'b0; stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (sample_valid_out || done_out) valids++;
        end
        n_cmp++; if (valids !== 0) begin n_fail++; $display("FAIL stop_no_valid: got %0d want 0", valids); end
        n_cmp++; if ({sample_out, playing_out} !== 9'd0) begin n_fail++; $display("FAIL stop_idle: got sample=%0d playing=%b want 0 0", sample_out, playing_out); end
        pulse_start(16'd0, 3'd0, 1'b0);
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1 audio_valid = 1'b1;
            @(negedge clk); if (bus.rd_en_out) ens++;
            @(posedge clk); #1 audio_valid = 1'b0;
        end
        n_cmp++; if ({playing_out, ens} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL zero_length: got playing=%b rd_en=%0d want 0 0", playing_out, ens); end
    endtask

    task automatic test_back_to_back();
        logic got, dn, en; logic signed [7:0] s; int lat; logic [15:0] a; exp_t e;
        int valids = 0;
        load_clip();
        pulse_start(16'd4, 3'd0, 1'b0);
        do_tick(got, s, lat, dn, en, a);
        do_tick(got, s, lat, dn, en, a);
        n_cmp++; if ({got, s, a} !== {1'b1, -8'sd20, 16'd1}) begin n_fail++; $display("FAIL b2b_second: got v=%b %0d addr=%0d want v=1 -20 addr=1", got, s, a); end
        @(posedge clk); #1 audio_valid = 1'b1;
        @(posedge clk); #1 audio_valid = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (sample_valid_out) valids++;
        end
        n_cmp++; if ({valids, playing_out} !== {32'd0, 1'b1}) begin n_fail++; $display("FAIL restart_abort: got valids=%0d playing=%b want 0 1", valids, playing_out); end
        e.s = 8'sd10; e.d = 1'b0; e.a = 16'd0;
        exp_q.push_back(e);
        do_tick(got, s, lat, dn, en, a);
        e = exp_q.pop_front();
        n_cmp++; if ({got, s, a} !== {1'b1, e.s, e.a}) begin n_fail++; $display("FAIL restart_first: got v=%b %0d addr=%0d want v=1 %0d addr=%0d", got, s, a, e.s, e.a); end
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic test_async_reset();
        logic got, dn, en; logic signed [7:0] s; int lat; logic [15:0] a;
        int valids = 0;
        int ens = 0;
        load_clip();
        pulse_start(16'd4, 3'd0, 1'b1);
        do_tick(got, s, lat, dn, en, a);
        @(posedge clk); #1 audio_valid = 1'b1;
        @(posedge clk); #1 audio_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({sample_out, sample_valid_out, playing_out, done_out, overrun_out, bus.rd_en_out} !== 20'd0) begin
            n_fail++; $display("FAIL async_reset: got sample=%0d playing=%b rd_en=%b want all 0", sample_out, playing_out, bus.rd_en_out);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (sample_valid_out) valids++;
        end
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1 audio_valid = 1'b1;
            @(negedge clk); if (bus.rd_en_out) ens++;
            @(posedge clk); #1 audio_valid = 1'b0;
        end
        n_cmp++; if ({valids, ens} !== 64'd0) begin n_fail++; $display("FAIL post_reset_idle: got valids=%0d rd_en=%0d want 0 0", valids, ens); end
        pulse_start(16'd4, 3'd0, 1'b0);
        do_tick(got, s, lat, dn, en, a);
        n_cmp++; if ({got, s, a} !== {1'b1, 8'sd10, 16'd0}) begin n_fail++; $display("FAIL post_reset_play: got v=%b %0d addr=%0d want v=1 10 addr=0", got, s, a); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_loop();
        test_shift();
        test_overrun();
        test_stop();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
